// File: rtl/pcie_phy_pkg.sv
// Shared PCIe PHY types and symbol constants for the ordered-set generator.
package pcie_phy_pkg;

  typedef enum logic [2:0] {
    OS_TS1   = 3'd0,
    OS_TS2   = 3'd1,
    OS_EIEOS = 3'd2,
    OS_SKP   = 3'd3,
    OS_EIOS  = 3'd4
  } os_type_e;

  // 8b/10b control and data symbols
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_7 = 8'hFC;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] D10_2 = 8'h4A;
  localparam logic [7:0] D5_2  = 8'h45;

  // 128b/130b ordered-set identifiers
  localparam logic [7:0] G3_TS1_ID  = 8'h1E;
  localparam logic [7:0] G3_TS2_ID  = 8'h2D;
  localparam logic [7:0] G3_SKP     = 8'hAA;
  localparam logic [7:0] G3_SKP_END = 8'hE1;
  localparam logic [7:0] G3_EIOS    = 8'h66;
  localparam logic [7:0] G3_PAD     = 8'hF7;
  localparam logic [1:0] G3_SYNC_OS = 2'b01;

  // Request fields captured when the generator accepts a request
  typedef struct packed {
    os_type_e   os_type;
    logic [7:0] link_num;
    logic       link_pad;
    logic [7:0] lane_base;
    logic       lane_pad;
    logic [7:0] n_fts;
    logic [7:0] rate_id;
    logic [7:0] train_ctl;
  } pcie_os_req_t;

  // Ordered-set length in symbols: short SKP/EIOS only exist in 8b/10b mode
  function automatic logic [4:0] os_len_f(input os_type_e t, input logic gen3);
    if (!gen3 && (t == OS_SKP || t == OS_EIOS)) begin
      return 5'd4;
    end
    return 5'd16;
  endfunction

endpackage

// File: rtl/pcie_os_gen_if.sv
// Request and beat-stream bundle between LTSSM, generator and lane encoders.
interface pcie_os_gen_if
  import pcie_phy_pkg::*;
#(
  parameter int LANES          = 4,
  parameter int SYMS_PER_CYCLE = 2,
  parameter int CNT_W          = 8
);
  localparam int NSYM = LANES * SYMS_PER_CYCLE;

  logic             req_valid;
  logic             req_ready;
  os_type_e         req_type;
  logic             req_gen3;
  logic [CNT_W-1:0] req_count;
  logic [7:0]       req_link_num;
  logic             req_link_pad;
  logic [7:0]       req_lane_base;
  logic             req_lane_pad;
  logic [7:0]       req_n_fts;
  logic [7:0]       req_rate_id;
  logic [7:0]       req_train_ctl;
  logic             abort;

  logic [NSYM*8-1:0] m_tdata;
  logic [NSYM-1:0]   m_tk;
  logic [1:0]        m_tsync;
  logic              m_tfirst;
  logic              m_tlast;
  logic              m_tvalid;
  logic              m_tready;
  logic              busy;

  // Generator side: accepts requests, sources the beat stream
  modport master (
    input  req_valid, req_type, req_gen3, req_count, req_link_num, req_link_pad,
           req_lane_base, req_lane_pad, req_n_fts, req_rate_id, req_train_ctl,
           abort, m_tready,
    output req_ready, m_tdata, m_tk, m_tsync, m_tfirst, m_tlast, m_tvalid, busy
  );

  // Environment side: issues requests, sinks the beat stream
  modport slave (
    output req_valid, req_type, req_gen3, req_count, req_link_num, req_link_pad,
           req_lane_base, req_lane_pad, req_n_fts, req_rate_id, req_train_ctl,
           abort, m_tready,
    input  req_ready, m_tdata, m_tk, m_tsync, m_tfirst, m_tlast, m_tvalid, busy
  );

endinterface

// File: rtl/pcie_os_sym_lut.sv
// Combinational symbol map: one lane, one symbol position of an ordered set.
module pcie_os_sym_lut
  import pcie_phy_pkg::*;
(
  input  pcie_os_req_t os_req,
  input  logic         gen3,
  input  logic [7:0]   lane,
  input  logic [3:0]   sym_idx,
  output logic [7:0]   sym,
  output logic         k
);

  logic [7:0] lane_num;
  logic [7:0] ts_fill;
  logic [7:0] g3_ts_id;

  // Select the symbol and K flag for this position from the ordered-set tables
  always_comb begin
    sym      = 8'h00;
    k        = 1'b0;
    lane_num = os_req.lane_base + lane;
    ts_fill  = (os_req.os_type == OS_TS1) ? D10_2 : D5_2;
    g3_ts_id = (os_req.os_type == OS_TS1) ? G3_TS1_ID : G3_TS2_ID;

    if (!gen3) begin
      unique case (os_req.os_type)
        OS_TS1, OS_TS2: begin
          unique case (sym_idx)
            4'd0: begin sym = K28_5; k = 1'b1; end
            4'd1: begin
              sym = os_req.link_pad ? K23_7 : os_req.link_num;
              k   = os_req.link_pad;
            end
            4'd2: begin
              sym = os_req.lane_pad ? K23_7 : lane_num;
              k   = os_req.lane_pad;
            end
            4'd3:    sym = os_req.n_fts;
            4'd4:    sym = os_req.rate_id;
            4'd5:    sym = os_req.train_ctl;
            default: sym = ts_fill;
          endcase
        end
        OS_EIEOS: begin
          if (sym_idx == 4'd0) begin
            sym = K28_5; k = 1'b1;
          end else if (sym_idx == 4'd15) begin
            sym = D10_2;
          end else begin
            sym = K28_7; k = 1'b1;
          end
        end
        OS_SKP: begin
          sym = (sym_idx == 4'd0) ? K28_5 : K28_0;
          k   = 1'b1;
        end
        OS_EIOS: begin
          sym = (sym_idx == 4'd0) ? K28_5 : K28_3;
          k   = 1'b1;
        end
        default: begin
          sym = 8'h00;
          k   = 1'b0;
        end
      endcase
    end else begin
      unique case (os_req.os_type)
        OS_TS1, OS_TS2: begin
          unique case (sym_idx)
            4'd0:    sym = g3_ts_id;
            4'd1:    sym = os_req.link_pad ? G3_PAD : os_req.link_num;
            4'd2:    sym = os_req.lane_pad ? G3_PAD : lane_num;
            4'd3:    sym = os_req.n_fts;
            4'd4:    sym = os_req.rate_id;
            4'd5:    sym = os_req.train_ctl;
            default: sym = ts_fill;
          endcase
        end
        OS_EIEOS: sym = sym_idx[0] ? 8'hFF : 8'h00;
        OS_SKP: begin
          if (sym_idx < 4'd12)       sym = G3_SKP;
          else if (sym_idx == 4'd12) sym = G3_SKP_END;
          else                       sym = 8'h00;
        end
        OS_EIOS: sym = G3_EIOS;
        default: sym = 8'h00;
      endcase
    end
  end

endmodule

// File: rtl/pcie_os_gen.sv
// Multi-lane ordered-set generator: request FSM, repeat counter, registered beat stream.
module pcie_os_gen
  import pcie_phy_pkg::*;
#(
  parameter int LANES          = 4,
  parameter int SYMS_PER_CYCLE = 2,
  parameter int CNT_W          = 8
)(
  input logic            clk,
  input logic            rst_n,
  pcie_os_gen_if.master  bus
);

  localparam int         NSYM = LANES * SYMS_PER_CYCLE;
  localparam int         DW   = NSYM * 8;
  localparam logic [4:0] SPC  = 5'(SYMS_PER_CYCLE);

  if (!(SYMS_PER_CYCLE == 1 || SYMS_PER_CYCLE == 2 || SYMS_PER_CYCLE == 4)) begin : g_bad_spc
    $error("pcie_os_gen: SYMS_PER_CYCLE must be 1, 2 or 4");
  end
  if (LANES < 1 || LANES > 16) begin : g_bad_lanes
    $error("pcie_os_gen: LANES must be in 1..16");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  pcie_os_req_t     req_q, req_d;
  logic             gen3_q, gen3_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [4:0]       sym_idx_q, sym_idx_d;
  logic             abort_pend_q, abort_pend_d;
  logic [DW-1:0]    tdata_q, tdata_d;
  logic [NSYM-1:0]  tk_q, tk_d;
  logic [1:0]       tsync_q, tsync_d;
  logic             tfirst_q, tfirst_d;
  logic             tlast_q, tlast_d;
  logic             tvalid_q, tvalid_d;

  pcie_os_req_t     in_req;
  pcie_os_req_t     lut_req;
  logic             lut_gen3;
  logic [3:0]       lut_idx;
  logic [DW-1:0]    lut_sym;
  logic [NSYM-1:0]  lut_k;
  logic [4:0]       cur_len;
  logic [4:0]       in_len;
  logic [4:0]       sym_adv;
  logic             os_end;
  logic [CNT_W-1:0] rep_next;

  // Gather the incoming request fields and work out where the current OS stands
  always_comb begin
    in_req.os_type   = bus.req_type;
    in_req.link_num  = bus.req_link_num;
    in_req.link_pad  = bus.req_link_pad;
    in_req.lane_base = bus.req_lane_base;
    in_req.lane_pad  = bus.req_lane_pad;
    in_req.n_fts     = bus.req_n_fts;
    in_req.rate_id   = bus.req_rate_id;
    in_req.train_ctl = bus.req_train_ctl;

    cur_len  = os_len_f(req_q.os_type, gen3_q);
    in_len   = os_len_f(bus.req_type, bus.req_gen3);
    sym_adv  = sym_idx_q + SPC;
    os_end   = (sym_adv == cur_len);
    rep_next = rep_cnt_q - CNT_W'(1);
  end

  // Point the symbol tables at the beat that will be registered next
  always_comb begin
    if (state_q == ST_IDLE) begin
      lut_req  = in_req;
      lut_gen3 = bus.req_gen3;
      lut_idx  = 4'd0;
    end else begin
      lut_req  = req_q;
      lut_gen3 = gen3_q;
      lut_idx  = os_end ? 4'd0 : sym_adv[3:0];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    for (genvar s = 0; s < SYMS_PER_CYCLE; s++) begin : g_sym
      pcie_os_sym_lut u_lut (
        .os_req  (lut_req),
        .gen3    (lut_gen3),
        .lane    (8'(l)),
        .sym_idx (lut_idx + 4'(s)),
        .sym     (lut_sym[(l*SYMS_PER_CYCLE+s)*8 +: 8]),
        .k       (lut_k[l*SYMS_PER_CYCLE+s])
      );
    end
  end

  // State register, counters and output beat registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      gen3_q       <= 1'b0;
      rep_cnt_q    <= '0;
      sym_idx_q    <= '0;
      abort_pend_q <= 1'b0;
      tdata_q      <= '0;
      tk_q         <= '0;
      tsync_q      <= 2'b00;
      tfirst_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      gen3_q       <= gen3_d;
      rep_cnt_q    <= rep_cnt_d;
      sym_idx_q    <= sym_idx_d;
      abort_pend_q <= abort_pend_d;
      tdata_q      <= tdata_d;
      tk_q         <= tk_d;
      tsync_q      <= tsync_d;
      tfirst_q     <= tfirst_d;
      tlast_q      <= tlast_d;
      tvalid_q     <= tvalid_d;
    end
  end

  // Next-state logic: accept in IDLE, stream beats in SEND, one bubble in DONE
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    gen3_d       = gen3_q;
    rep_cnt_d    = rep_cnt_q;
    sym_idx_d    = sym_idx_q;
    abort_pend_d = abort_pend_q;
    tdata_d      = tdata_q;
    tk_d         = tk_q;
    tsync_d      = tsync_q;
    tfirst_d     = tfirst_q;
    tlast_d      = tlast_q;
    tvalid_d     = tvalid_q;

    unique case (state_q)
      ST_IDLE: begin
        abort_pend_d = 1'b0;
        if (bus.req_valid) begin
          state_d   = ST_SEND;
          req_d     = in_req;
          gen3_d    = bus.req_gen3;
          rep_cnt_d = (bus.req_count == '0) ? CNT_W'(1) : bus.req_count;
          sym_idx_d = 5'd0;
          tdata_d   = lut_sym;
          tk_d      = lut_k;
          tsync_d   = bus.req_gen3 ? G3_SYNC_OS : 2'b00;
          tfirst_d  = 1'b1;
          tlast_d   = (SPC == in_len);
          tvalid_d  = 1'b1;
        end
      end
      ST_SEND: begin
        if (bus.abort) begin
          abort_pend_d = 1'b1;
        end
        if (bus.m_tready) begin
          if (os_end && (rep_next == '0 || abort_pend_q)) begin
            state_d   = ST_DONE;
            rep_cnt_d = rep_next;
            sym_idx_d = 5'd0;
            tdata_d   = '0;
            tk_d      = '0;
            tsync_d   = 2'b00;
            tfirst_d  = 1'b0;
            tlast_d   = 1'b0;
            tvalid_d  = 1'b0;
          end else begin
            if (os_end) begin
              rep_cnt_d = rep_next;
            end
            sym_idx_d = os_end ? 5'd0 : sym_adv;
            tdata_d   = lut_sym;
            tk_d      = lut_k;
            tsync_d   = (os_end && gen3_q) ? G3_SYNC_OS : 2'b00;
            tfirst_d  = os_end;
            tlast_d   = ((os_end ? SPC : (sym_adv + SPC)) == cur_len);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.m_tdata   = tdata_q;
  assign bus.m_tk      = tk_q;
  assign bus.m_tsync   = tsync_q;
  assign bus.m_tfirst  = tfirst_q;
  assign bus.m_tlast   = tlast_q;
  assign bus.m_tvalid  = tvalid_q;

endmodule

// File: tb/tb_pcie_os_gen.sv
// Self-checking bench for pcie_os_gen: directed and randomized bursts against a table model.
module tb_pcie_os_gen;
  import pcie_phy_pkg::*;

  localparam int L  = 4;
  localparam int S  = 2;
  localparam int CW = 8;
  localparam int DW = L * S * 8;
  localparam int KW = L * S;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  pcie_os_gen_if #(.LANES(L), .SYMS_PER_CYCLE(S), .CNT_W(CW)) bus ();

  pcie_os_gen #(.LANES(L), .SYMS_PER_CYCLE(S), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int testCount = 0;
  int failCount = 0;

  // Current request as the bench intends it
  os_type_e   tType;
  bit         tGen3;
  int         tCount;
  logic [7:0] tLink, tBase, tNfts, tRate, tTc;
  bit         tLinkPad, tLanePad;

  logic [DW-1:0] firstData;
  logic [KW-1:0] firstK;

  // One comparison: counts it, and counts and reports a mismatch
  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Whole ordered set for one lane, filled from the symbol tables
  function automatic void buildOs(input int lane, output logic [127:0] syms, output logic [15:0] ks);
    logic [7:0] fill;
    logic [7:0] laneNum;
    laneNum = 8'((int'(tBase) + lane) % 256);
    syms = '0;
    ks   = '0;
    if (!tGen3) begin
      case (tType)
        OS_TS1, OS_TS2: begin
          fill = (tType == OS_TS1) ? 8'h4A : 8'h45;
          for (int i = 0; i < 16; i++) syms[i*8 +: 8] = fill;
          syms[7:0]   = 8'hBC; ks[0] = 1'b1;
          syms[15:8]  = tLinkPad ? 8'hF7 : tLink;   ks[1] = tLinkPad;
          syms[23:16] = tLanePad ? 8'hF7 : laneNum; ks[2] = tLanePad;
          syms[31:24] = tNfts;
          syms[39:32] = tRate;
          syms[47:40] = tTc;
        end
        OS_EIEOS: begin
          for (int i = 0; i < 16; i++) begin syms[i*8 +: 8] = 8'hFC; ks[i] = 1'b1; end
          syms[7:0] = 8'hBC;
          syms[127:120] = 8'h4A; ks[15] = 1'b0;
        end
        OS_SKP: begin
          for (int i = 0; i < 4; i++) begin syms[i*8 +: 8] = 8'h1C; ks[i] = 1'b1; end
          syms[7:0] = 8'hBC;
        end
        OS_EIOS: begin
          for (int i = 0; i < 4; i++) begin syms[i*8 +: 8] = 8'h7C; ks[i] = 1'b1; end
          syms[7:0] = 8'hBC;
        end
        default: ;
      endcase
    end else begin
      case (tType)
        OS_TS1, OS_TS2: begin
          fill = (tType == OS_TS1) ? 8'h4A : 8'h45;
          for (int i = 0; i < 16; i++) syms[i*8 +: 8] = fill;
          syms[7:0]   = (tType == OS_TS1) ? 8'h1E : 8'h2D;
          syms[15:8]  = tLinkPad ? 8'hF7 : tLink;
          syms[23:16] = tLanePad ? 8'hF7 : laneNum;
          syms[31:24] = tNfts;
          syms[39:32] = tRate;
          syms[47:40] = tTc;
        end
        OS_EIEOS: for (int i = 0; i < 16; i++) syms[i*8 +: 8] = (i % 2 == 1) ? 8'hFF : 8'h00;
        OS_SKP: begin
          for (int i = 0; i < 12; i++) syms[i*8 +: 8] = 8'hAA;
          syms[103:96] = 8'hE1;
        end
        OS_EIOS: for (int i = 0; i < 16; i++) syms[i*8 +: 8] = 8'h66;
        default: ;
      endcase
    end
  endfunction

  // Present the bench's current request on the interface
  task automatic applyStimulus();
    bus.req_type      = tType;
    bus.req_gen3      = tGen3;
    bus.req_count     = CW'(tCount);
    bus.req_link_num  = tLink;
    bus.req_link_pad  = tLinkPad;
    bus.req_lane_base = tBase;
    bus.req_lane_pad  = tLanePad;
    bus.req_n_fts     = tNfts;
    bus.req_rate_id   = tRate;
    bus.req_train_ctl = tTc;
    bus.req_valid     = 1'b1;
  endtask

  task automatic randomFields();
    tLink    = 8'($urandom);
    tBase    = 8'($urandom);
    tNfts    = 8'($urandom);
    tRate    = 8'($urandom);
    tTc      = 8'($urandom);
    tLinkPad = 1'($urandom_range(0, 1));
    tLanePad = 1'($urandom_range(0, 1));
  endtask

  // Issue the request and check every beat of the burst, the bubble and the return to idle
  task automatic runBurst(input string name, input int abortBeat, input bit randReady, input bit noise);
    int len, bpo, effCnt, nOs, expBeats, got, cycles, b;
    bit rdy, abortDone;
    logic [127:0] ls [L];
    logic [15:0]  lk [L];
    logic [DW-1:0] ed;
    logic [KW-1:0] ek;
    logic [1:0]    es;

    len    = (!tGen3 && (tType == OS_SKP || tType == OS_EIOS)) ? 4 : 16;
    bpo    = len / S;
    effCnt = (tCount == 0) ? 1 : tCount;
    nOs    = effCnt;
    if (abortBeat >= 0 && (abortBeat / bpo + 1) < nOs) nOs = abortBeat / bpo + 1;
    expBeats = nOs * bpo;
    for (int l = 0; l < L; l++) buildOs(l, ls[l], lk[l]);

    applyStimulus();
    checkOutput({name, "/req_ready_idle"}, 128'(bus.req_ready), 128'(1));
    @(posedge clk); #1;
    if (noise) begin
      bus.req_type      = os_type_e'(3'($urandom_range(0, 4)));
      bus.req_gen3      = ~tGen3;
      bus.req_count     = 8'($urandom);
      bus.req_lane_base = 8'($urandom);
      bus.req_link_num  = 8'($urandom);
    end else begin
      bus.req_valid = 1'b0;
    end
    checkOutput({name, "/busy_ready"}, 128'({bus.busy, bus.req_ready}), 128'(2'b10));

    got = 0; cycles = 0; abortDone = 1'b0;
    while (got < expBeats && cycles < 4000) begin
      b = got % bpo;
      for (int l = 0; l < L; l++) begin
        for (int s = 0; s < S; s++) begin
          ed[(l*S+s)*8 +: 8] = ls[l][(b*S+s)*8 +: 8];
          ek[l*S+s]          = lk[l][b*S+s];
        end
      end
      es = (tGen3 && b == 0) ? 2'b01 : 2'b00;
      checkOutput({name, "/beat"},
        128'({bus.m_tvalid, bus.m_tfirst, bus.m_tlast, bus.m_tsync, bus.m_tk, bus.m_tdata}),
        128'({1'b1, (b == 0), (b == bpo - 1), es, ek, ed}));
      if (got == 0) begin
        firstData = bus.m_tdata;
        firstK    = bus.m_tk;
      end
      if (!abortDone && abortBeat >= 0 && got == abortBeat) begin
        bus.abort = 1'b1;
        abortDone = 1'b1;
      end
      rdy = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.m_tready = rdy;
      if (noise && got == 2) bus.req_valid = 1'b0;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      if (rdy) got++;
      cycles++;
    end
    bus.req_valid = 1'b0;
    bus.m_tready  = 1'b1;
    checkOutput({name, "/beat_count"}, 128'(got), 128'(expBeats));
    checkOutput({name, "/done_bubble"}, 128'({bus.m_tvalid, bus.req_ready, bus.busy}), 128'(3'b001));
    @(posedge clk); #1;
    checkOutput({name, "/back_idle"}, 128'({bus.m_tvalid, bus.req_ready, bus.busy}), 128'(3'b010));
    bus.m_tready = 1'b0;
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.abort     = 1'b0;
    bus.m_tready  = 1'b0;
    tType = OS_TS1; tGen3 = 1'b0; tCount = 1;
    randomFields();
    applyStimulus();
    bus.req_valid = 1'b0;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    checkOutput("reset_outputs",
      128'({bus.m_tvalid, bus.m_tfirst, bus.m_tlast, bus.m_tsync, bus.m_tk, bus.m_tdata, bus.busy, bus.req_ready}),
      128'(1));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // TS1 Gen1, count 2, link 0, lane base 0, no pads
    randomFields();
    tType = OS_TS1; tGen3 = 1'b0; tCount = 2;
    tLink = 8'h00; tBase = 8'h00; tLinkPad = 1'b0; tLanePad = 1'b0;
    runBurst("ts1_g1", -1, 1'b0, 1'b0);
    checkOutput("ts1_g1/lane3_beat0", 128'(firstData[63:48]), 128'(16'h00BC));
    checkOutput("ts1_g1/k_beat0", 128'(firstK), 128'(8'h55));

    // TS2 Gen3 with both pads, request lines disturbed during the burst
    randomFields();
    tType = OS_TS2; tGen3 = 1'b1; tCount = 1; tLinkPad = 1'b1; tLanePad = 1'b1;
    runBurst("ts2_g3", -1, 1'b0, 1'b1);
    checkOutput("ts2_g3/lane0_beat0", 128'(firstData[15:0]), 128'(16'hF72D));
    checkOutput("ts2_g3/k_beat0", 128'(firstK), 128'(0));

    // SKP Gen1, count 3
    randomFields();
    tType = OS_SKP; tGen3 = 1'b0; tCount = 3;
    runBurst("skp_g1", -1, 1'b0, 1'b0);
    checkOutput("skp_g1/lane0_beat0", 128'(firstData[15:0]), 128'(16'h1CBC));
    checkOutput("skp_g1/k_beat0", 128'(firstK), 128'(8'hFF));

    // EIEOS Gen3, count 4, random backpressure
    randomFields();
    tType = OS_EIEOS; tGen3 = 1'b1; tCount = 4;
    runBurst("eieos_g3_stall", -1, 1'b1, 1'b0);

    // TS1 count 10, abort in the middle of the third OS
    randomFields();
    tType = OS_TS1; tGen3 = 1'b0; tCount = 10;
    runBurst("ts1_abort", 19, 1'b0, 1'b0);

    // Following burst must run to its full count
    randomFields();
    tType = OS_TS2; tGen3 = 1'b0; tCount = 2;
    runBurst("after_abort", -1, 1'b0, 1'b0);

    // Count 0 behaves as 1
    randomFields();
    tType = OS_EIOS; tGen3 = 1'b1; tCount = 0;
    runBurst("count_zero", -1, 1'b0, 1'b0);

    // Randomized bursts
    for (int r = 0; r < 8; r++) begin
      randomFields();
      tType  = os_type_e'(3'($urandom_range(0, 4)));
      tGen3  = 1'($urandom_range(0, 1));
      tCount = $urandom_range(0, 5);
      runBurst("random", (r == 5) ? 5 : -1, 1'b1, r[0]);
    end

    // Reset in the middle of an EIOS burst
    randomFields();
    tType = OS_EIOS; tGen3 = 1'b0; tCount = 20;
    applyStimulus();
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.m_tready  = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midburst_reset",
      128'({bus.m_tvalid, bus.m_tfirst, bus.m_tlast, bus.m_tsync, bus.m_tk, bus.m_tdata, bus.busy, bus.req_ready}),
      128'(1));
    bus.m_tready = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    tCount = 2;
    runBurst("eios_after_reset", -1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/pcie_os_gen.md
Name: pcie_os_gen

Overview:
- Multi-lane PCIe physical-layer ordered-set generator. Emits TS1, TS2, EIEOS, SKP and EIOS symbol streams in Gen1/2 (8b/10b) or Gen3 (128b/130b) format.
- Output is a parametrised-width valid/ready beat stream; every lane carries the same ordered set except for its per-lane lane number.
- Sits between the LTSSM (request side) and the per-lane scrambler/encoder (stream side).

Parameters:
- LANES, 4, number of lanes (1..16).
- SYMS_PER_CYCLE, 2, symbols per lane per beat; legal values 1, 2, 4.
- CNT_W, 8, width of the repeat count.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request strobe.
- req_ready  out  1  generator idle, request accepted when valid&ready.
- req_type  in  3  os_type_e: OS_TS1, OS_TS2, OS_EIEOS, OS_SKP, OS_EIOS.
- req_gen3  in  1  1 = 128b/130b format, 0 = 8b/10b format.
- req_count  in  CNT_W  number of ordered sets to send; 0 is treated as 1.
- req_link_num  in  8  link number; PAD is used when req_link_pad=1.
- req_link_pad  in  1  send PAD in the link field.
- req_lane_base  in  8  lane L sends req_lane_base+L (mod 256).
- req_lane_pad  in  1  send PAD in the lane field.
- req_n_fts  in  8  N_FTS field.
- req_rate_id  in  8  rate identifier field.
- req_train_ctl  in  8  training control field.
- abort  in  1  stop at the next ordered-set boundary.
- m_tdata  out  LANES*SYMS_PER_CYCLE*8  symbols; lane L owns slice L, symbol 0 in the LSBs.
- m_tk  out  LANES*SYMS_PER_CYCLE  per-symbol K flag; always 0 in Gen3.
- m_tsync  out  2  sync header; valid on the first beat of an ordered set in Gen3, 0 otherwise.
- m_tfirst  out  1  first beat of an ordered set.
- m_tlast  out  1  last beat of an ordered set.
- m_tvalid  out  1  output beat valid.
- m_tready  in  1  downstream accept.
- busy  out  1  a request is in progress.

Behaviour:
- Reset values: every output 0, except req_ready=1. FSM returns to IDLE, all counters cleared. Reset mid-burst abandons the burst immediately with no partial flush.
- FSM states:
  - IDLE: req_ready=1. On req_valid, latch all req_* fields, set rep_cnt=max(req_count,1), sym_idx=0, go to SEND.
  - SEND: m_tvalid=1. Beat contents are fully registered and held stable while m_tready=0. On each accepted beat, sym_idx advances by SYMS_PER_CYCLE.
    - At OS end (sym_idx+SYMS_PER_CYCLE==os_len), rep_cnt decrements. If rep_cnt reaches 0 or abort_pend=1, go to DONE; otherwise restart at sym_idx=0.
  - DONE: one bubble cycle with m_tvalid=0, then IDLE.
- Latency: request accepted in cycle T → first beat valid in T+1. Minimum gap between bursts is 2 cycles.
- abort: sampled in SEND into sticky abort_pend, cleared in IDLE. The current OS always completes; abort never truncates an OS. Abort in the same cycle as the final beat of the burst has no extra effect.
- os_len: 16 symbols, except Gen1/2 SKP and Gen1/2 EIOS, which are 4. SYMS_PER_CYCLE must divide os_len; an elaboration-time check rejects any other value.
- Gen1/2 symbol maps (K = K-flag set):
  - TS1/TS2: s0 K28.5 (K); s1 link number, or K23.7 (K) if padded; s2 lane number, or K23.7 (K) if padded; s3 n_fts; s4 rate_id; s5 train_ctl; s6..15 4Ah (TS1) or 45h (TS2).
  - EIEOS: s0 K28.5, s1..14 K28.7, s15 4Ah (D10.2, not K).
  - SKP: K28.5 followed by 3× K28.0.
  - EIOS: K28.5 followed by 3× K28.3.
- Gen3 symbol maps (m_tsync=2'b01, sent once per OS):
  - TS1/TS2: s0 1Eh (TS1) or 2Dh (TS2); s1..5 as in Gen1/2, with PAD = F7h; s6..15 4Ah (TS1) or 45h (TS2).
  - EIEOS: even symbols 00h, odd symbols FFh.
  - SKP: s0..11 AAh, s12 E1h, s13..15 00h.
  - EIOS: 16× 66h.
- req_ready is low in SEND and DONE; req_valid in those states is ignored and leaves no side effects.

Decomposition:
- Additions to pcie_phy_pkg:
  - os_type_e.
  - Gen3 ordered-set identifier constants (1Eh, 2Dh, AAh, E1h, 66h, F7h).
  - D10_2 constant.
  - pcie_os_req_t, a packed struct of the latched request fields.
- Sub-module pcie_os_sym_lut: purely combinational map (os_req, gen3, lane, sym_idx) → {symbol, k}. It is instantiated LANES×SYMS_PER_CYCLE times; pcie_os_gen holds the FSM, counters and output registers.

Test Plan:
- LANES=4, SYMS=2, TS1 Gen1, count 2, link 0, lane_base 0, both pads=0 → 16 beats. Beat 0 lane3 = {00h, BCh(K)}, lane1 s2 = 01h, s6..15 = 4Ah. m_tfirst on beats 0 and 8, m_tlast on beats 7 and 15.
- TS2 Gen3, pads=1, count 1 → m_tsync=01 on beat 0 only. s0=2Dh, s1=s2=F7h, s6..15=45h, m_tk all 0.
- SKP Gen1/2 with SYMS=2, count 3 → 6 beats of {BCh K, 1Ch K} / {1Ch K, 1Ch K}, m_tlast every 2nd beat. Then the DONE bubble, and req_ready returns 2 cycles after the last accept.
- EIEOS Gen3, count 4, m_tready toggling randomly → data stable while stalled, exactly 32 accepted beats, even symbols 00h / odd symbols FFh.
- TS1, count 10, abort asserted mid-OS 3 → OS 3 completes, exactly 3 OS sent, abort_pend cleared when IDLE is reached.
- rst_n asserted mid-EIOS → all outputs 0 immediately, req_ready=1. Next request after release starts at symbol 0.
